// File: rtl/vx_mem_router_pkg.sv
// vx_mem_router_pkg: target-index width macro, packed-field slice macros and lane width helper for vx_mem_router
`define VX_TGT_W(n) (((n) > 1) ? $clog2(n) : 1)
`define VX_SLICE(v, i, w) v[(i)*(w) +: (w)]
package vx_mem_router_pkg;
  function automatic int lane_w(input int word_size);
    return word_size * 8;
  endfunction
endpackage

// File: rtl/vx_rr_arbiter.sv
// vx_rr_arbiter: round-robin one-hot grant starting at ptr_q; ptr_q moves to winner+1 when enable_i and a request is granted
//   clk_i, reset_i (async, active-high) | requests_i: request vector | enable_i: advance | grant_o: one-hot grant
import vx_mem_router_pkg::*;
module vx_rr_arbiter #(
  parameter int NUM_REQS = 2
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [NUM_REQS-1:0] requests_i,
  input  logic                enable_i,
  output logic [NUM_REQS-1:0] grant_o
);
  localparam int PW = `VX_TGT_W(NUM_REQS);
  logic [PW-1:0] ptr_q, ptr_d, win;
  logic [NUM_REQS-1:0] rot;
  logic found;
  int w;
  always_comb begin
    rot = NUM_REQS'({requests_i, requests_i} >> ptr_q);
    found = 1'b0;
    win = '0;
    w = 0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        w = int'(ptr_q) + i;
        w = (w >= NUM_REQS) ? w - NUM_REQS : w;
        win = PW'(w);
      end
    end
    grant_o = found ? ({{(NUM_REQS-1){1'b0}}, 1'b1} << win) : '0;
    ptr_d = (int'(win) == NUM_REQS - 1) ? '0 : win + 1'b1;
  end
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) ptr_q <= '0;
    else if (enable_i && found) ptr_q <= ptr_d;
endmodule

// File: rtl/vx_mem_router.sv
// vx_mem_router: routes one multi-lane core port to NUM_TARGETS slaves by address window, with credits and RR response merge
//   clk_i, reset_i (async, active-high)
//   core_req_*_i / core_req_ready_o : core request in  -> tgt_req_*_o / tgt_req_ready_i : broadcast request out
//   tgt_rsp_*_i / tgt_rsp_ready_o   : target responses -> core_rsp_*_o / core_rsp_ready_i : merged response out
//   MEM_ROUTER_PERF_EN: adds perf_req_count_o (per-target fires) and perf_stall_cycles_o (blocked entry cycles)
import vx_mem_router_pkg::*;
module vx_mem_router #(
  parameter int NUM_REQUESTS = 4,
  parameter int NUM_TARGETS = 2,
  parameter int WORD_SIZE = 4,
  parameter int ADDR_WIDTH = 30,
  parameter int TAG_WIDTH = 8,
  parameter logic [NUM_TARGETS*ADDR_WIDTH-1:0] TGT_BASE = '0,
  parameter logic [NUM_TARGETS*ADDR_WIDTH-1:0] TGT_SIZE = '0,
  parameter int MAX_PENDING = 8
) (
  input  logic                                        clk_i,
  input  logic                                        reset_i,
  input  logic [NUM_REQUESTS-1:0]                     core_req_valid_i,
  input  logic                                        core_req_rw_i,
  input  logic [NUM_REQUESTS*WORD_SIZE-1:0]           core_req_byteen_i,
  input  logic [NUM_REQUESTS*ADDR_WIDTH-1:0]          core_req_addr_i,
  input  logic [NUM_REQUESTS*WORD_SIZE*8-1:0]         core_req_data_i,
  input  logic [TAG_WIDTH-1:0]                        core_req_tag_i,
  output logic                                        core_req_ready_o,
  output logic [NUM_TARGETS*NUM_REQUESTS-1:0]         tgt_req_valid_o,
  output logic                                        tgt_req_rw_o,
  output logic [NUM_REQUESTS*WORD_SIZE-1:0]           tgt_req_byteen_o,
  output logic [NUM_REQUESTS*ADDR_WIDTH-1:0]          tgt_req_addr_o,
  output logic [NUM_REQUESTS*WORD_SIZE*8-1:0]         tgt_req_data_o,
  output logic [TAG_WIDTH-1:0]                        tgt_req_tag_o,
  input  logic [NUM_TARGETS-1:0]                      tgt_req_ready_i,
  input  logic [NUM_TARGETS*NUM_REQUESTS-1:0]         tgt_rsp_valid_i,
  input  logic [NUM_TARGETS*NUM_REQUESTS*WORD_SIZE*8-1:0] tgt_rsp_data_i,
  input  logic [NUM_TARGETS*TAG_WIDTH-1:0]            tgt_rsp_tag_i,
  output logic [NUM_TARGETS-1:0]                      tgt_rsp_ready_o,
  output logic [NUM_REQUESTS-1:0]                     core_rsp_valid_o,
  output logic [NUM_REQUESTS*WORD_SIZE*8-1:0]         core_rsp_data_o,
  output logic [TAG_WIDTH-1:0]                        core_rsp_tag_o,
`ifdef MEM_ROUTER_PERF_EN
  output logic [NUM_TARGETS*32-1:0]                   perf_req_count_o,
  output logic [31:0]                                 perf_stall_cycles_o,
`endif
  input  logic                                        core_rsp_ready_i
);
  localparam int LW = lane_w(WORD_SIZE);
  localparam int TI = `VX_TGT_W(NUM_TARGETS);
  localparam int CW = $clog2(MAX_PENDING + 1);
  logic [ADDR_WIDTH-1:0] key_addr;
  logic [TI-1:0] dec_tgt, req_tgt_q;
  logic req_full_q, req_rw_q, issue_ok, req_fire, core_req_fire;
  logic [NUM_REQUESTS-1:0] req_valid_q;
  logic [NUM_REQUESTS*WORD_SIZE-1:0] req_byteen_q;
  logic [NUM_REQUESTS*ADDR_WIDTH-1:0] req_addr_q;
  logic [NUM_REQUESTS*LW-1:0] req_data_q;
  logic [TAG_WIDTH-1:0] req_tag_q;
  logic [CW-1:0] credit_q [NUM_TARGETS];
  logic [CW-1:0] credit_d [NUM_TARGETS];
  logic [NUM_TARGETS-1:0] rsp_any, grant, tgt_rsp_fire;
  logic rsp_full_q, rsp_accept, core_rsp_fire;
  logic [NUM_REQUESTS-1:0] rsp_valid_q, rsp_valid_d;
  logic [NUM_REQUESTS*LW-1:0] rsp_data_q, rsp_data_d;
  logic [TAG_WIDTH-1:0] rsp_tag_q, rsp_tag_d;
  // Key lane is the lowest valid one; the lowest-index hitting window wins, target 0 catches the rest.
  always_comb begin
    key_addr = `VX_SLICE(core_req_addr_i, 0, ADDR_WIDTH);
    for (int l = NUM_REQUESTS - 1; l >= 0; l--)
      if (core_req_valid_i[l]) key_addr = `VX_SLICE(core_req_addr_i, l, ADDR_WIDTH);
    dec_tgt = '0;
    for (int t = NUM_TARGETS - 1; t > 0; t--)
      if ((key_addr - `VX_SLICE(TGT_BASE, t, ADDR_WIDTH)) < `VX_SLICE(TGT_SIZE, t, ADDR_WIDTH)) dec_tgt = TI'(t);
  end
  // Reads wait for a free credit on their target; writes are never throttled.
  assign issue_ok = req_full_q & (req_rw_q | (credit_q[req_tgt_q] < CW'(MAX_PENDING)));
  assign req_fire = issue_ok & tgt_req_ready_i[req_tgt_q];
  assign core_req_ready_o = !req_full_q | req_fire;
  assign core_req_fire = (|core_req_valid_i) & core_req_ready_o;
  assign tgt_req_rw_o = req_rw_q;
  assign tgt_req_byteen_o = req_byteen_q;
  assign tgt_req_addr_o = req_addr_q;
  assign tgt_req_data_o = req_data_q;
  assign tgt_req_tag_o = req_tag_q;
  always_comb begin
    tgt_req_valid_o = '0;
    for (int t = 0; t < NUM_TARGETS; t++)
      `VX_SLICE(tgt_req_valid_o, t, NUM_REQUESTS) = (issue_ok && req_tgt_q == TI'(t)) ? req_valid_q : '0;
  end
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      req_full_q <= 1'b0;
      req_valid_q <= '0;
      req_rw_q <= 1'b0;
      req_byteen_q <= '0;
      req_addr_q <= '0;
      req_data_q <= '0;
      req_tag_q <= '0;
      req_tgt_q <= '0;
    end else if (core_req_fire) begin
      req_full_q <= 1'b1;
      req_valid_q <= core_req_valid_i;
      req_rw_q <= core_req_rw_i;
      req_byteen_q <= core_req_byteen_i;
      req_addr_q <= core_req_addr_i;
      req_data_q <= core_req_data_i;
      req_tag_q <= core_req_tag_i;
      req_tgt_q <= dec_tgt;
    end else if (req_fire) req_full_q <= 1'b0;
  // Simultaneous issue and return cancel out; a stray return leaves the count at zero.
  always_comb
    for (int t = 0; t < NUM_TARGETS; t++) begin
      credit_d[t] = credit_q[t];
      if (req_fire && !req_rw_q && req_tgt_q == TI'(t) && !tgt_rsp_fire[t]) credit_d[t] = credit_q[t] + 1'b1;
      else if (tgt_rsp_fire[t] && !(req_fire && !req_rw_q && req_tgt_q == TI'(t)) && credit_q[t] != '0)
        credit_d[t] = credit_q[t] - 1'b1;
    end
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) for (int t = 0; t < NUM_TARGETS; t++) credit_q[t] <= '0;
    else
      for (int t = 0; t < NUM_TARGETS; t++) begin
        credit_q[t] <= credit_d[t];
        assert (!(tgt_rsp_fire[t] && credit_q[t] == '0))
          else $error("vx_mem_router: response from target %0d with no outstanding read", t);
      end
  always_comb
    for (int t = 0; t < NUM_TARGETS; t++) rsp_any[t] = |`VX_SLICE(tgt_rsp_valid_i, t, NUM_REQUESTS);
  assign core_rsp_fire = rsp_full_q & core_rsp_ready_i;
  assign rsp_accept = !rsp_full_q | core_rsp_fire;
  assign tgt_rsp_ready_o = grant & {NUM_TARGETS{rsp_accept}};
  assign tgt_rsp_fire = tgt_rsp_ready_o & rsp_any;
  vx_rr_arbiter #(.NUM_REQS(NUM_TARGETS)) rsp_arb (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .requests_i(rsp_any),
    .enable_i(rsp_accept),
    .grant_o(grant)
  );
  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d = '0;
    rsp_tag_d = '0;
    for (int t = 0; t < NUM_TARGETS; t++)
      if (grant[t]) begin
        rsp_valid_d = `VX_SLICE(tgt_rsp_valid_i, t, NUM_REQUESTS);
        rsp_data_d = `VX_SLICE(tgt_rsp_data_i, t, NUM_REQUESTS*LW);
        rsp_tag_d = `VX_SLICE(tgt_rsp_tag_i, t, TAG_WIDTH);
      end
  end
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      rsp_full_q <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q <= '0;
      rsp_tag_q <= '0;
    end else if (|tgt_rsp_fire) begin
      rsp_full_q <= 1'b1;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q <= rsp_data_d;
      rsp_tag_q <= rsp_tag_d;
    end else if (core_rsp_fire) rsp_full_q <= 1'b0;
  assign core_rsp_valid_o = rsp_full_q ? rsp_valid_q : '0;
  assign core_rsp_data_o = rsp_data_q;
  assign core_rsp_tag_o = rsp_tag_q;
`ifdef MEM_ROUTER_PERF_EN
  logic [31:0] perf_req_q [NUM_TARGETS];
  logic [31:0] perf_stall_q;
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      for (int t = 0; t < NUM_TARGETS; t++) perf_req_q[t] <= '0;
      perf_stall_q <= '0;
    end else begin
      for (int t = 0; t < NUM_TARGETS; t++)
        if (req_fire && req_tgt_q == TI'(t)) perf_req_q[t] <= perf_req_q[t] + 32'd1;
      if (req_full_q && !req_fire) perf_stall_q <= perf_stall_q + 32'd1;
    end
  always_comb
    for (int t = 0; t < NUM_TARGETS; t++) perf_req_count_o[t*32 +: 32] = perf_req_q[t];
  assign perf_stall_cycles_o = perf_stall_q;
`endif
endmodule

// File: tb/tb_vx_mem_router.sv
// tb_vx_mem_router: randomized and directed checks of decode, credits, RR merge, response hold and mid-run reset
module tb_vx_mem_router;
  localparam logic [59:0] BASE = {30'h3F000000, 30'h0};
  localparam logic [59:0] SIZE = {30'h400, 30'h0};
  logic clk = 1'b0;
  logic reset;
  logic [3:0] core_req_valid;
  logic core_req_rw;
  logic [15:0] core_req_byteen;
  logic [119:0] core_req_addr;
  logic [127:0] core_req_data;
  logic [7:0] core_req_tag;
  logic core_req_ready;
  logic [7:0] tgt_req_valid;
  logic tgt_req_rw;
  logic [15:0] tgt_req_byteen;
  logic [119:0] tgt_req_addr;
  logic [127:0] tgt_req_data;
  logic [7:0] tgt_req_tag;
  logic [1:0] tgt_req_ready;
  logic [7:0] tgt_rsp_valid;
  logic [255:0] tgt_rsp_data;
  logic [15:0] tgt_rsp_tag;
  logic [1:0] tgt_rsp_ready;
  logic [3:0] core_rsp_valid;
  logic [127:0] core_rsp_data;
  logic [7:0] core_rsp_tag;
  logic core_rsp_ready;
  int vectors = 0;
  int miscompares = 0;

  vx_mem_router #(
    .NUM_REQUESTS(4), .NUM_TARGETS(2), .WORD_SIZE(4), .ADDR_WIDTH(30), .TAG_WIDTH(8),
    .TGT_BASE(BASE), .TGT_SIZE(SIZE), .MAX_PENDING(2)
  ) dut (
    .clk_i(clk), .reset_i(reset),
    .core_req_valid_i(core_req_valid), .core_req_rw_i(core_req_rw), .core_req_byteen_i(core_req_byteen),
    .core_req_addr_i(core_req_addr), .core_req_data_i(core_req_data), .core_req_tag_i(core_req_tag),
    .core_req_ready_o(core_req_ready),
    .tgt_req_valid_o(tgt_req_valid), .tgt_req_rw_o(tgt_req_rw), .tgt_req_byteen_o(tgt_req_byteen),
    .tgt_req_addr_o(tgt_req_addr), .tgt_req_data_o(tgt_req_data), .tgt_req_tag_o(tgt_req_tag),
    .tgt_req_ready_i(tgt_req_ready),
    .tgt_rsp_valid_i(tgt_rsp_valid), .tgt_rsp_data_i(tgt_rsp_data), .tgt_rsp_tag_i(tgt_rsp_tag),
    .tgt_rsp_ready_o(tgt_rsp_ready),
    .core_rsp_valid_o(core_rsp_valid), .core_rsp_data_o(core_rsp_data), .core_rsp_tag_o(core_rsp_tag),
    .core_rsp_ready_i(core_rsp_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference decode: first valid lane's address, inside [0x3F000000, 0x3F0003FF] goes to target 1.
  function automatic int route(input logic [3:0] m, input logic [119:0] a);
    logic [29:0] k;
    bit found;
    found = 0;
    k = a[29:0];
    for (int l = 0; l < 4; l++)
      if (m[l] && !found) begin
        found = 1;
        k = a[l*30 +: 30];
      end
    return (k >= 30'h3F000000 && k <= 30'h3F0003FF) ? 1 : 0;
  endfunction

  function automatic logic [29:0] pick();
    case ($urandom_range(0, 5))
      0: return 30'h3F000000 + 30'($urandom_range(0, 1023));
      1: return 30'h3F0003FF;
      2: return 30'h3F000400;
      3: return 30'h3EFFFFFF;
      4: return 30'h3F000000;
      default: return 30'($urandom);
    endcase
  endfunction

  task automatic idle_inputs();
    core_req_valid = '0;
    core_req_rw = 1'b0;
    core_req_byteen = '0;
    core_req_addr = '0;
    core_req_data = '0;
    core_req_tag = '0;
    tgt_req_ready = 2'b11;
    tgt_rsp_valid = '0;
    tgt_rsp_data = '0;
    tgt_rsp_tag = '0;
    core_rsp_ready = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drive_req(input logic [3:0] m, input logic rw, input logic [29:0] a, input logic [7:0] tg);
    core_req_valid = m;
    core_req_rw = rw;
    core_req_addr = {4{a}};
    core_req_tag = tg;
    core_req_data = {$urandom, $urandom, $urandom, $urandom};
    core_req_byteen = 16'($urandom);
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    #1;
    vectors++;
    if ({core_req_ready, tgt_req_valid, tgt_rsp_ready, core_rsp_valid} !== {1'b1, 8'h0, 2'b0, 4'h0})
      $display("FAIL reset_state got ready=%b tv=%h trr=%b crv=%h want ready=1 tv=00 trr=00 crv=0",
               core_req_ready, tgt_req_valid, tgt_rsp_ready, core_rsp_valid);
    if ({core_req_ready, tgt_req_valid, tgt_rsp_ready, core_rsp_valid} !== {1'b1, 8'h0, 2'b0, 4'h0}) miscompares++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_decode();
    logic [7:0] exp_v;
    logic [119:0] exp_a;
    logic [127:0] exp_d;
    logic [7:0] exp_t;
    logic [3:0] m;
    logic [119:0] a;
    do_reset();
    exp_v = '0;
    exp_a = '0;
    exp_d = '0;
    exp_t = '0;
    for (int i = 0; i < 41; i++) begin
      @(negedge clk);
      if (i < 40) begin
        m = (i == 0) ? 4'b1110 : (i < 5) ? 4'b0001 : 4'($urandom_range(1, 15));
        for (int l = 0; l < 4; l++) a[l*30 +: 30] = pick();
        if (i == 0) a[59:0] = {30'h3F000010, 30'h00000010};
        if (i == 1) a[29:0] = 30'h3F0003FF;
        if (i == 2) a[29:0] = 30'h3F000400;
        if (i == 3) a[29:0] = 30'h3EFFFFFF;
        if (i == 4) a[29:0] = 30'h3F000000;
        drive_req(m, 1'b1, '0, 8'($urandom));
        core_req_addr = a;
      end else core_req_valid = '0;
      #1;
      vectors++;
      if (tgt_req_valid !== exp_v) begin
        miscompares++;
        $display("FAIL decode_valid step %0d got %h want %h", i, tgt_req_valid, exp_v);
      end
      if (exp_v != 0) begin
        vectors++;
        if ({tgt_req_addr, tgt_req_data, tgt_req_tag, tgt_req_rw} !== {exp_a, exp_d, exp_t, 1'b1}) begin
          miscompares++;
          $display("FAIL decode_fields step %0d got addr=%h tag=%h want addr=%h tag=%h", i, tgt_req_addr, tgt_req_tag, exp_a, exp_t);
        end
      end
      vectors++;
      if (core_req_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL decode_ready step %0d got %b want 1", i, core_req_ready);
      end
      exp_v = (i < 40) ? (8'(m) << (4 * route(m, a))) : 8'h0;
      exp_a = core_req_addr;
      exp_d = core_req_data;
      exp_t = core_req_tag;
    end
  endtask

  task automatic test_credit();
    do_reset();
    @(negedge clk); drive_req(4'b0001, 1'b0, 30'h0, 8'd1);
    @(negedge clk); drive_req(4'b0001, 1'b0, 30'h0, 8'd2);
    #1; vectors++;
    if ({tgt_req_valid, tgt_req_tag, core_req_ready} !== {8'h01, 8'd1, 1'b1}) begin
      miscompares++;
      $display("FAIL credit_rd1 got tv=%h tag=%0d rdy=%b want 01 1 1", tgt_req_valid, tgt_req_tag, core_req_ready);
    end
    @(negedge clk); drive_req(4'b0001, 1'b0, 30'h0, 8'd3);
    #1; vectors++;
    if ({tgt_req_valid, tgt_req_tag, core_req_ready} !== {8'h01, 8'd2, 1'b1}) begin
      miscompares++;
      $display("FAIL credit_rd2 got tv=%h tag=%0d rdy=%b want 01 2 1", tgt_req_valid, tgt_req_tag, core_req_ready);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); core_req_valid = '0;
      #1; vectors++;
      if ({tgt_req_valid, core_req_ready} !== {8'h00, 1'b0}) begin
        miscompares++;
        $display("FAIL credit_block cycle %0d got tv=%h rdy=%b want 00 0", k, tgt_req_valid, core_req_ready);
      end
    end
    @(negedge clk);
    tgt_rsp_valid = 8'h01;
    tgt_rsp_tag = 16'h00AA;
    #1; vectors++;
    if ({tgt_rsp_ready, tgt_req_valid} !== {2'b01, 8'h00}) begin
      miscompares++;
      $display("FAIL credit_rsp got trr=%b tv=%h want 01 00", tgt_rsp_ready, tgt_req_valid);
    end
    @(negedge clk);
    tgt_rsp_valid = '0;
    #1; vectors++;
    if ({tgt_req_valid, tgt_req_tag, core_req_ready, core_rsp_valid, core_rsp_tag} !== {8'h01, 8'd3, 1'b1, 4'h1, 8'hAA}) begin
      miscompares++;
      $display("FAIL credit_release got tv=%h tag=%0d rdy=%b crv=%h ctag=%h want 01 3 1 1 aa",
               tgt_req_valid, tgt_req_tag, core_req_ready, core_rsp_valid, core_rsp_tag);
    end
    @(negedge clk); drive_req(4'b0011, 1'b1, 30'h0, 8'd4);
    @(negedge clk); drive_req(4'b0001, 1'b0, 30'h0, 8'd5);
    #1; vectors++;
    if ({tgt_req_valid, tgt_req_tag, tgt_req_rw} !== {8'h03, 8'd4, 1'b1}) begin
      miscompares++;
      $display("FAIL credit_write got tv=%h tag=%0d rw=%b want 03 4 1", tgt_req_valid, tgt_req_tag, tgt_req_rw);
    end
    @(negedge clk); core_req_valid = '0;
    #1; vectors++;
    if ({tgt_req_valid, core_req_ready} !== {8'h00, 1'b0}) begin
      miscompares++;
      $display("FAIL credit_full_read got tv=%h rdy=%b want 00 0", tgt_req_valid, core_req_ready);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk); drive_req(4'b0001, 1'b0, 30'h0, 8'd1);
    @(negedge clk); drive_req(4'b0001, 1'b0, 30'h0, 8'd2);
    @(negedge clk); drive_req(4'b0001, 1'b0, 30'h3F000000, 8'd3);
    @(negedge clk); drive_req(4'b0001, 1'b0, 30'h3F000004, 8'd4);
    @(negedge clk); core_req_valid = '0;
    #1; vectors++;
    if ({tgt_req_valid, tgt_req_tag} !== {8'h10, 8'd4}) begin
      miscompares++;
      $display("FAIL midreset_pre got tv=%h tag=%0d want 10 4", tgt_req_valid, tgt_req_tag);
    end
    reset = 1'b1;
    #1; vectors++;
    if ({tgt_req_valid, core_rsp_valid, tgt_rsp_ready, core_req_ready} !== {8'h00, 4'h0, 2'b00, 1'b1}) begin
      miscompares++;
      $display("FAIL midreset_clear got tv=%h crv=%h trr=%b rdy=%b want 00 0 00 1",
               tgt_req_valid, core_rsp_valid, tgt_rsp_ready, core_req_ready);
    end
    @(negedge clk); reset = 1'b0;
    @(negedge clk); drive_req(4'b0001, 1'b0, 30'h0, 8'd5);
    @(negedge clk); drive_req(4'b0001, 1'b0, 30'h0, 8'd6);
    #1; vectors++;
    if ({tgt_req_valid, tgt_req_tag} !== {8'h01, 8'd5}) begin
      miscompares++;
      $display("FAIL midreset_cr1 got tv=%h tag=%0d want 01 5", tgt_req_valid, tgt_req_tag);
    end
    @(negedge clk); drive_req(4'b0001, 1'b0, 30'h0, 8'd7);
    #1; vectors++;
    if ({tgt_req_valid, tgt_req_tag} !== {8'h01, 8'd6}) begin
      miscompares++;
      $display("FAIL midreset_cr2 got tv=%h tag=%0d want 01 6", tgt_req_valid, tgt_req_tag);
    end
    @(negedge clk); core_req_valid = '0;
    #1; vectors++;
    if ({tgt_req_valid, core_req_ready} !== {8'h00, 1'b0}) begin
      miscompares++;
      $display("FAIL midreset_cr3 got tv=%h rdy=%b want 00 0", tgt_req_valid, core_req_ready);
    end
  endtask

  // Bench-side targets answer their outstanding reads; the model tracks RR order and the one-entry output stage.
  task automatic test_rsp_merge(input bit stall);
    int cnt[2];
    int ptr, w, delivered, cyc;
    bit sv, acc;
    logic [1:0] exp_r;
    logic [3:0] smask;
    logic [127:0] sdata;
    logic [7:0] stag;
    logic [3:0] cur_m[2];
    logic [127:0] cur_d[2];
    logic [7:0] cur_t[2];
    do_reset();
    @(negedge clk); drive_req(4'b0001, 1'b0, 30'h0, 8'd1);
    @(negedge clk); drive_req(4'b0001, 1'b0, 30'h0, 8'd2);
    @(negedge clk); drive_req(4'b0001, 1'b0, 30'h3F000000, 8'd3);
    @(negedge clk); drive_req(4'b0001, 1'b0, 30'h3F000001, 8'd4);
    @(negedge clk); core_req_valid = '0;
    @(negedge clk);
    cnt[0] = 2; cnt[1] = 2;
    for (int t = 0; t < 2; t++) begin
      cur_m[t] = 4'($urandom_range(1, 15));
      cur_d[t] = {$urandom, $urandom, $urandom, $urandom};
      cur_t[t] = 8'($urandom);
    end
    ptr = 0; sv = 0; delivered = 0; cyc = 0;
    smask = '0; sdata = '0; stag = '0;
    while (!(delivered == 4 && !sv) && cyc < 40) begin
      @(negedge clk);
      for (int t = 0; t < 2; t++) begin
        tgt_rsp_valid[t*4 +: 4] = (cnt[t] > 0) ? cur_m[t] : 4'h0;
        tgt_rsp_data[t*128 +: 128] = cur_d[t];
        tgt_rsp_tag[t*8 +: 8] = cur_t[t];
      end
      core_rsp_ready = !(stall && cyc < 5);
      #1;
      w = -1;
      for (int k = 0; k < 2; k++)
        if (w < 0 && cnt[(ptr + k) % 2] > 0) w = (ptr + k) % 2;
      acc = !sv || core_rsp_ready;
      exp_r = (w >= 0 && acc) ? 2'(1 << w) : 2'b00;
      vectors++;
      if (tgt_rsp_ready !== exp_r) begin
        miscompares++;
        $display("FAIL rsp_grant stall=%0d cycle %0d got %b want %b", stall, cyc, tgt_rsp_ready, exp_r);
      end
      vectors++;
      if (core_rsp_valid !== (sv ? smask : 4'h0)) begin
        miscompares++;
        $display("FAIL rsp_valid stall=%0d cycle %0d got %h want %h", stall, cyc, core_rsp_valid, sv ? smask : 4'h0);
      end
      if (sv) begin
        vectors++;
        if ({core_rsp_data, core_rsp_tag} !== {sdata, stag}) begin
          miscompares++;
          $display("FAIL rsp_payload stall=%0d cycle %0d got tag=%h data=%h want tag=%h data=%h",
                   stall, cyc, core_rsp_tag, core_rsp_data, stag, sdata);
        end
      end
      if (sv && core_rsp_ready) begin
        sv = 0;
        delivered++;
      end
      if (exp_r != 0) begin
        sv = 1;
        smask = cur_m[w];
        sdata = cur_d[w];
        stag = cur_t[w];
        cnt[w]--;
        ptr = (w + 1) % 2;
        cur_m[w] = 4'($urandom_range(1, 15));
        cur_d[w] = {$urandom, $urandom, $urandom, $urandom};
        cur_t[w] = 8'($urandom);
      end
      cyc++;
    end
    tgt_rsp_valid = '0;
    vectors++;
    if (delivered != 4) begin
      miscompares++;
      $display("FAIL rsp_delivered stall=%0d got %0d want 4", stall, delivered);
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_credit();
    test_rsp_merge(1'b0);
    test_rsp_merge(1'b1);
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
